// File: rtl/nd_sr.sv
// rtl/nd_sr.sv - clocked SR flip-flop bank with complementary outputs and S=R=1 policy
// BOTH_MODE selects the S=R=1 response: 0 hold, 1 set, 2 reset, 3 toggle, others hold.
module nd_sr #(
   parameter int WIDTH     = 1,
   parameter int BOTH_MODE = 0
) (
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             clk,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb,
   input  logic             rst,
   output logic [WIDTH-1:0] illegal
);

   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] illegal_next;

   always_comb begin
      q_next       = q;
      illegal_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case ({s[i], r[i]})
            2'b01: q_next[i] = 1'b0;
            2'b10: q_next[i] = 1'b1;
            2'b11: begin
               illegal_next[i] = 1'b1;
               case (BOTH_MODE)
                  1:       q_next[i] = 1'b1;
                  2:       q_next[i] = 1'b0;
                  3:       q_next[i] = ~q[i];
                  default: q_next[i] = q[i];
               endcase
            end
            default: q_next[i] = q[i];
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q       <= '0;
         illegal <= '0;
      end else begin
         q       <= q_next;
         illegal <= illegal_next;
      end
   end

   // qb derives from the register only, so the NAND "both high" state cannot occur
   assign qb = ~q;

endmodule

// File: tb/tb_nd_sr.sv
// tb/tb_nd_sr.sv - randomized and directed bench for nd_sr across all BOTH_MODE policies
module tb_nd_sr;

   localparam int N = 5;

   logic       clk = 1'b0;
   logic       run = 1'b1;
   logic       rst;
   logic [3:0] s, r;
   logic [3:0] q_o [N];
   logic [3:0] qb_o [N];
   logic [3:0] ill_o [N];
   logic       q1, qb1, ill1;

   int checks = 0;
   int errors = 0;

   // per-instance reference state: index 0..3 = mode 0..3, index 4 = mode 5 (out of range)
   int         mode_of [N] = '{0, 1, 2, 3, 5};
   logic [3:0] mq [N];
   logic [3:0] mi [N];

   always begin
      #5;
      if (run) clk = ~clk;
   end

   for (genvar g = 0; g < N; g++) begin : g_dut
      nd_sr #(.WIDTH(4), .BOTH_MODE(g == 4 ? 5 : g)) dut (
         .s(s), .r(r), .clk(clk), .q(q_o[g]), .qb(qb_o[g]), .rst(rst), .illegal(ill_o[g])
      );
   end

   nd_sr dut_w1 (
      .s(s[0]), .r(r[0]), .clk(clk), .q(q1), .qb(qb1), .rst(rst), .illegal(ill1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic next_bit(int mode, logic cur, logic sb, logic rb);
      if (sb && !rb) return 1'b1;
      if (!sb && rb) return 1'b0;
      if (!sb && !rb) return cur;
      if (mode == 1) return 1'b1;
      if (mode == 2) return 1'b0;
      if (mode == 3) return !cur;
      return cur;
   endfunction

   task automatic model_edge();
      for (int k = 0; k < N; k++) begin
         for (int b = 0; b < 4; b++) begin
            if (rst) begin
               mq[k][b] = 1'b0;
               mi[k][b] = 1'b0;
            end else begin
               mi[k][b] = s[b] & r[b];
               mq[k][b] = next_bit(mode_of[k], mq[k][b], s[b], r[b]);
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < N; k++) begin
         check($sformatf("%s q m%0d", tag, mode_of[k]), {28'd0, q_o[k]}, {28'd0, mq[k]});
         check($sformatf("%s qb m%0d", tag, mode_of[k]), {28'd0, qb_o[k]}, {28'd0, ~mq[k]});
         check($sformatf("%s ill m%0d", tag, mode_of[k]), {28'd0, ill_o[k]}, {28'd0, mi[k]});
      end
      check({tag, " w1 q"}, {31'd0, q1}, {31'd0, mq[0][0]});
      check({tag, " w1 qb"}, {31'd0, qb1}, {31'd0, ~mq[0][0]});
      check({tag, " w1 ill"}, {31'd0, ill1}, {31'd0, mi[0][0]});
   endtask

   task automatic tick(input string tag, input logic rv, input logic [3:0] sv, input logic [3:0] rv4);
      rst = rv;
      s   = sv;
      r   = rv4;
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      rst = 1'b0;
      s   = '0;
      r   = '0;
      @(negedge clk);

      tick("reset", 1'b1, 4'b0001, 4'b0000);
      check("reset q const", {28'd0, q_o[0]}, 32'd0);
      tick("release", 1'b0, 4'b0000, 4'b0000);

      tick("tt set", 1'b0, 4'b0001, 4'b0000);
      check("tt set const", {31'd0, q1}, 32'd1);
      tick("tt hold", 1'b0, 4'b0000, 4'b0000);
      tick("tt rst", 1'b0, 4'b0000, 4'b0001);
      tick("tt rst2", 1'b0, 4'b0000, 4'b0001);

      tick("forb pre", 1'b0, 4'b0001, 4'b0000);
      tick("forb 11", 1'b0, 4'b0001, 4'b0001);
      check("forb ill const", {31'd0, ill1}, 32'd1);
      check("forb q const", {31'd0, q1}, 32'd1);
      tick("forb clr", 1'b0, 4'b0000, 4'b0000);
      check("forb ill clr const", {31'd0, ill1}, 32'd0);

      tick("sweep pre", 1'b0, 4'b0000, 4'b1111);
      for (int i = 0; i < 3; i++) begin
         tick($sformatf("sweep %0d", i), 1'b0, 4'b1111, 4'b1111);
         check($sformatf("sweep m3 const %0d", i), {28'd0, q_o[3]}, (i == 1) ? 32'h0 : 32'hf);
         check($sformatf("sweep m1 const %0d", i), {28'd0, q_o[1]}, 32'hf);
         check($sformatf("sweep m2 const %0d", i), {28'd0, q_o[2]}, 32'h0);
      end

      // no clock: freeze with clk high, wiggle inputs, outputs must not move
      tick("noclk pre", 1'b0, 4'b0101, 4'b0000);
      run = 1'b0;
      begin
         logic [3:0] pats_s [3] = '{4'b0000, 4'b1111, 4'b1111};
         logic [3:0] pats_r [3] = '{4'b1111, 4'b0000, 4'b1111};
         for (int i = 0; i < 3; i++) begin
            s = pats_s[i];
            r = pats_r[i];
            #20;
            check_all($sformatf("noclk %0d", i));
         end
      end
      s = '0;
      r = '0;
      run = 1'b1;

      tick("mb reset", 1'b1, 4'b0000, 4'b0000);
      tick("mb apply", 1'b0, 4'b1010, 4'b0110);
      check("mb q const", {28'd0, q_o[0]}, 32'h8);
      check("mb ill const", {28'd0, ill_o[0]}, 32'h2);
      tick("mb rst11", 1'b1, 4'b1111, 4'b1111);
      check("mb rst q const", {28'd0, q_o[3]}, 32'h0);
      check("mb rst ill const", {28'd0, ill_o[3]}, 32'h0);

      for (int i = 0; i < 300; i++) begin
         tick($sformatf("rand %0d", i), ($urandom_range(0, 19) == 0),
              4'($urandom), 4'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nd_sr.md
# nd_sr

Clocked SR flip-flop bank modelled on the classic NAND-gated SR flip-flop, made synchronous and fully deterministic. Each bit samples its set (`s`) and reset (`r`) inputs on the rising clock edge and updates a complementary output pair (`q`/`qb`). The forbidden S=R=1 condition resolves by a parameterised policy and is reported on a per-bit `illegal` flag. Intended as a basic storage/flag primitive in control logic.

## Interface
Parameters:
- `WIDTH`, default 1: number of independent SR bits.
- `BOTH_MODE`, default 0: response to S=R=1. 0 = hold, 1 = force set, 2 = force reset, 3 = toggle.

Ports (clock and reset listed first):
- `clk`  input  1  rising-edge clock; the single clock for the block.
- `rst`  input  1  reset, synchronous and active-high.
- `s`  input  WIDTH  per-bit set request.
- `r`  input  WIDTH  per-bit reset request.
- `q`  output  WIDTH  registered state.
- `qb`  output  WIDTH  complement of `q`.
- `illegal`  output  WIDTH  registered flag: S=R=1 was sampled on the previous edge.

Positional port order is `s, r, clk, q, qb, rst, illegal`, so that existing 5-port positional instantiations stay valid. `rst` must be driven in every instance.

## Operation
- All state changes occur only on a `clk` rising edge. No latch behaviour and no combinational path from `s`/`r` to `q`.
- `rst`=1 at an edge overrides everything: `q`=0, `qb`=all ones, `illegal`=0.
- Each bit i is evaluated independently using `{s[i],r[i]}` at the edge:
  - 00: hold `q[i]`.
  - 01: `q[i]`=0.
  - 10: `q[i]`=1.
  - 11: apply `BOTH_MODE`. Hold keeps `q[i]`. Set gives `q[i]`=1. Reset gives `q[i]`=0. Toggle gives `q[i]`=~`q[i]`.
- `qb` is always exactly `~q`. The NAND "both outputs high" state is never produced.
- `illegal[i]` is set to 1 on an edge sampling S=R=1 for bit i. It is set to 0 on any other sampled combination. It is not sticky.
- Out-of-range `BOTH_MODE` values (>3) behave as hold.
- X/Z on `s`/`r` is not defined; the bench drives only 0/1.

## Timing
- Latency: one clock. Inputs sampled at edge N appear on `q`/`qb`/`illegal` after edge N, stable until edge N+1.
- Reset latency: one clock. The first edge with `rst`=1 sets the reset values.
- Before the first reset edge, output values are undefined. Simulation initial values are not relied upon.
- Deassertion of `rst` takes effect at the next edge: normal S/R evaluation resumes on the first edge with `rst`=0.
- `rst` asserted mid-operation, together with any S/R combination, gives reset values. `illegal` is cleared even if S=R=1.
- Without clock edges, outputs hold indefinitely regardless of `s`/`r` activity.
- Setup/hold relative to `clk` only; no asynchronous inputs.

## Test plan
- Reset: drive `rst`=1 with S=1,R=0 for one edge -> `q`=0, `qb`=1, `illegal`=0. Release `rst` with S=R=0 -> `q` stays 0.
- Basic truth table (WIDTH=1, BOTH_MODE=0), one edge each:
  - S=1,R=0 -> `q`=1, `qb`=0.
  - S=0,R=0 -> `q`=1 held.
  - S=0,R=1 -> `q`=0, `qb`=1.
  - S=0,R=1 again -> `q`=0.
- Forbidden input: from `q`=1 apply S=R=1 -> `q`=1, `qb`=0, `illegal`=1. Next edge S=R=0 -> `illegal`=0.
- BOTH_MODE sweep: from `q`=0 apply S=R=1 for three consecutive edges.
  - Mode 1 -> `q` 1,1,1.
  - Mode 2 -> `q` 0,0,0.
  - Mode 3 -> `q` 1,0,1.
  - `illegal`=1 on each of those edges.
- No clock: hold `clk` high, change S/R through 01, 10, 11 -> `q`/`qb` unchanged.
- Multi-bit (WIDTH=4), from reset: apply `s`=1010, `r`=0110 -> `q`=1000 and `illegal`=0010. Bit 1 keeps its prior value of 0 under mode 0. Then assert `rst` with `s`=1111 -> `q`=0000.
